iter_divider: RTL and testbench

Parametrised multicycle integer divider for the CPU execute stage. It takes one quotient bit per cycle using radix-2 restoring division on operand magnitudes. It supports signed and unsigned modes and gives RISC-V-compatible results for divide-by-zero and signed overflow. Operands and results use valid/ready handshakes, and a flush input cancels an in-flight operation on pipeline redirect.

---
 rtl/iter_divider.sv | 179 +++++++++++++++++
 tb/tb_iter_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: multicycle radix-2 restoring integer divider, one quotient bit
// per cycle, operating on operand magnitudes with sign correction at the end.
// Divide-by-zero and signed overflow follow RISC-V conventions and complete
// without iterating.
//
// Parameters:
//   WIDTH        operand/result width (>= 4)
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   flush        synchronous cancel of any accepted or pending operation
//   in_valid/in_ready    operand handshake (in_ready high only when idle)
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   dividend, divisor    operands
//   out_valid/out_ready  result handshake (result held until out_ready)
//   quotient, remainder  results (truncating division, remainder has
//                        the dividend's sign)
//   div_by_zero  divisor was zero, qualified by out_valid
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, the iteration count is reduced to the
//                     significant length of |dividend| (minimum 1).

module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] dvs_mag;
  // Partial remainder is always below |divisor|, so only WIDTH bits need
  // storing; the WIDTH+1-bit value exists only as the shifted trial operand.
  logic [WIDTH-1:0] prem;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [WIDTH-1:0] q_sh;
  logic [CW-1:0]    cnt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand decode at the accept edge
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag_in;
  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH-1:0] q_init;
  logic [CW-1:0]    cnt_init;

  assign dvd_neg    = is_signed & dividend[WIDTH-1];
  assign dvs_neg    = is_signed & divisor[WIDTH-1];
  assign dvd_mag    = dvd_neg ? ('0 - dividend) : dividend;
  assign dvs_mag_in = dvs_neg ? ('0 - divisor)  : divisor;
  assign is_zero    = (divisor == '0);
  assign is_ovf     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
  function automatic logic [CW-1:0] clz(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = CW'(WIDTH);
    // Ascending scan: the highest set bit is the last to overwrite n.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CW'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  logic [CW-1:0] lz;
  assign lz       = clz(dvd_mag);
  // A zero dividend still runs one iteration; the shift leaves q_sh all zero.
  assign cnt_init = (lz == CW'(WIDTH)) ? CW'(1) : (CW'(WIDTH) - lz);
  assign q_init   = dvd_mag << lz;
`else
  assign cnt_init = CW'(WIDTH);
  assign q_init   = dvd_mag;
`endif

  // One restoring step
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    rem_sh = {prem, q_sh[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_mag};
    fits   = ~diff[WIDTH];
    q_next = {q_sh[WIDTH-2:0], fits};
    r_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_fin  = neg_q ? ('0 - q_next) : q_next;
    r_fin  = neg_r ? ('0 - r_next) : r_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvs_mag     <= '0;
      prem        <= '0;
      q_sh        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else if (is_ovf) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              state       <= DONE;
            end else begin
              neg_q   <= dvd_neg ^ dvs_neg;
              neg_r   <= dvd_neg;
              dvs_mag <= dvs_mag_in;
              prem    <= '0;
              q_sh    <= q_init;
              cnt     <= cnt_init;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          q_sh <= q_next;
          prem <= r_next;
          // The final iteration writes the sign-corrected result directly.
          if (cnt == CW'(1)) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH=32): directed cases, handshake,
// flush/reset cancellation and randomized operands against a 64-bit
// arithmetic reference.

module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the divide-by-zero rule.
  // lat counts edges from the accept edge (inclusive) to out_valid.
  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint sa, sb, qq, rr, mag;
    int bl;
    if (b == 32'd0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
      return;
    end
    dz = 1'b0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    qq = sa / sb;
    rr = sa % sb;
    q = qq[31:0];
    r = rr[31:0];
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      return;
    end
    mag = (sa < 0) ? -sa : sa;
    bl = 0;
    while ((mag >> bl) != 0) bl++;
`ifdef DIV_EARLY_OUT_EN
    lat = ((bl == 0) ? 1 : bl) + 1;
`else
    lat = 33;
`endif
  endfunction

  task automatic wait_result(input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input int elat, input int hold);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
    end
  endtask

  task automatic accept(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sg; dividend = a; divisor = b; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the pins: the divider must be working from latched copies.
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eq, er;
    logic edz;
    int elat;
    model(sg, a, b, eq, er, edz, elat);
    accept(sg, a, b);
    wait_result(eq, er, edz, elat, hold);
    release_result();
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic edz, sg, seen;
    int elat;

    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b0, 32'd5, 32'd0, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'd0, 32'd3, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);

    // Backpressure for 10 cycles, then release with the next request waiting
    model(1'b0, 32'd1000, 32'd13, eq, er, edz, elat);
    accept(1'b0, 32'd1000, 32'd13);
    wait_result(eq, er, edz, elat, 10);
    @(negedge clk);
    is_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd9;  // -100 / 9
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;                 // handshake edge N
    out_ready = 1'b0;
    check("b2b_valid_drop", out_valid, 0);
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;                 // accept edge N+1
    in_valid = 1'b0;
    check("b2b_accepted", in_ready, 0);
    model(1'b1, 32'hFFFF_FF9C, 32'd9, eq, er, edz, elat);
    wait_result(eq, er, edz, elat, 0);
    release_result();

    // Flush in CALC cycle 10
    accept(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 0);
    run_op(1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-operation
    accept(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_quotient", quotient, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 0);

    // Flush beats in_valid in IDLE
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("flush_idle_no_valid", out_valid, 0);

    // Flush together with out_ready in DONE: one completion, outputs kept
    accept(1'b0, 32'd20, 32'd0);
    check("flush_done_valid", out_valid, 1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_drop", out_valid, 0);
    check("flush_done_in_ready", in_ready, 1);
    check("flush_done_q_kept", quotient, 32'hFFFF_FFFF);
    check("flush_done_r_kept", remainder, 32'd20);
    @(posedge clk); #1;
    check("flush_done_single", out_valid, 0);

    // Randomized operands
    for (int n = 0; n < 250; n++) begin
      sg = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(sg, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
